// File: rtl/aluop_pkg.sv
// aluop_pkg: shared constants and types for the RV32I decode-and-issue stage.
// Holds opcode constants, the ALU operation codes, operand-select
// encodings, the decoded bundle struct and the buffer occupancy states.
package aluop_pkg;

  // RV32I major opcodes
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  // ALU operation codes, bits [4:0] of the operation word
  localparam logic [4:0] ALU_ADD  = 5'b00000;
  localparam logic [4:0] ALU_SUB  = 5'b00001;
  localparam logic [4:0] ALU_SLL  = 5'b00010;
  localparam logic [4:0] ALU_SLT  = 5'b00100;
  localparam logic [4:0] ALU_SLTU = 5'b00110;
  localparam logic [4:0] ALU_XOR  = 5'b01000;
  localparam logic [4:0] ALU_SRL  = 5'b01010;
  localparam logic [4:0] ALU_SRA  = 5'b01011;
  localparam logic [4:0] ALU_OR   = 5'b01100;
  localparam logic [4:0] ALU_AND  = 5'b01110;
  localparam logic [4:0] ALU_BEQ  = 5'b10000;
  localparam logic [4:0] ALU_BNE  = 5'b10010;
  localparam logic [4:0] ALU_BLT  = 5'b11000;
  localparam logic [4:0] ALU_BGE  = 5'b11010;
  localparam logic [4:0] ALU_BLTU = 5'b11100;
  localparam logic [4:0] ALU_BGEU = 5'b11110;

  // Jump bit of the 6-bit operation word
  localparam logic [5:0] ALU_JUMP = 6'b100000;

  // Operand select encodings
  localparam logic [1:0] SRC1_RS1  = 2'b00;
  localparam logic [1:0] SRC1_PC   = 2'b01;
  localparam logic [1:0] SRC1_ZERO = 2'b10;
  localparam logic       SRC2_RS2  = 1'b0;
  localparam logic       SRC2_IMM  = 1'b1;

  // Decoded bundle presented to the ALU
  typedef struct packed {
    logic [5:0]  aluop;
    logic [1:0]  src1_sel;
    logic        src2_sel;
    logic [31:0] imm;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic        wen;
    logic        illegal;
  } bundle_t;

  // Output buffer occupancy
  typedef enum logic [1:0] {
    OCC_EMPTY = 2'b00,
    OCC_ONE   = 2'b01,
    OCC_TWO   = 2'b10
  } occ_e;

  // Register/immediate arithmetic op from funct3 and the alternate bit
  function automatic logic [4:0] arith_op(input logic [2:0] f3, input logic alt);
    logic [4:0] op;
    case (f3)
      3'b000:  op = alt ? ALU_SUB : ALU_ADD;
      3'b001:  op = ALU_SLL;
      3'b010:  op = ALU_SLT;
      3'b011:  op = ALU_SLTU;
      3'b100:  op = ALU_XOR;
      3'b101:  op = alt ? ALU_SRA : ALU_SRL;
      3'b110:  op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

  // Branch compare op from funct3; 010/011 are rejected by the decoder
  function automatic logic [4:0] branch_op(input logic [2:0] f3);
    logic [4:0] op;
    case (f3)
      3'b000:  op = ALU_BEQ;
      3'b001:  op = ALU_BNE;
      3'b100:  op = ALU_BLT;
      3'b101:  op = ALU_BGE;
      3'b110:  op = ALU_BLTU;
      3'b111:  op = ALU_BGEU;
      default: op = ALU_ADD;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/aluop_decode.sv
// aluop_decode: purely combinational RV32I instruction -> decoded bundle.
module aluop_decode
  import aluop_pkg::*;
(
  input  logic [31:0] inst,
  output bundle_t     dec
);

  logic [6:0]  opc;
  logic [6:0]  f7;
  logic [2:0]  f3;
  logic [31:0] imm_i;
  logic [31:0] imm_s;
  logic [31:0] imm_b;
  logic [31:0] imm_u;
  logic [31:0] imm_j;
  logic [31:0] imm_sh;
  logic        bad;

  assign opc    = inst[6:0];
  assign f3     = inst[14:12];
  assign f7     = inst[31:25];
  assign imm_i  = {{20{inst[31]}}, inst[31:20]};
  assign imm_s  = {{20{inst[31]}}, inst[31:25], inst[11:7]};
  assign imm_b  = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
  assign imm_u  = {inst[31:12], 12'b0};
  assign imm_j  = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
  // Immediate shifts carry only the shift amount; funct7 is an opcode field
  assign imm_sh = {27'b0, inst[24:20]};

  // Decode by opcode, then apply x0 write suppression and the illegal override
  always_comb begin
    dec          = '0;
    dec.rs1      = inst[19:15];
    dec.rs2      = inst[24:20];
    dec.rd       = inst[11:7];
    dec.src1_sel = SRC1_RS1;
    dec.src2_sel = SRC2_RS2;
    bad          = 1'b0;
    case (opc)
      OPC_OP: begin
        dec.aluop = {1'b0, arith_op(f3, f7[5])};
        dec.wen   = 1'b1;
        if (f7 == 7'h20) begin
          if (f3 != 3'b000 && f3 != 3'b101) bad = 1'b1;
        end else if (f7 != 7'h00) begin
          bad = 1'b1;
        end
      end
      OPC_OPIMM: begin
        dec.aluop    = {1'b0, arith_op(f3, (f3 == 3'b101) & f7[5])};
        dec.src2_sel = SRC2_IMM;
        dec.imm      = imm_i;
        dec.wen      = 1'b1;
        if (f3 == 3'b001) begin
          dec.imm = imm_sh;
          if (f7 != 7'h00) bad = 1'b1;
        end else if (f3 == 3'b101) begin
          dec.imm = imm_sh;
          if (f7 != 7'h00 && f7 != 7'h20) bad = 1'b1;
        end
      end
      OPC_LUI: begin
        dec.aluop    = {1'b0, ALU_ADD};
        dec.src1_sel = SRC1_ZERO;
        dec.src2_sel = SRC2_IMM;
        dec.imm      = imm_u;
        dec.wen      = 1'b1;
      end
      OPC_AUIPC: begin
        dec.aluop    = {1'b0, ALU_ADD};
        dec.src1_sel = SRC1_PC;
        dec.src2_sel = SRC2_IMM;
        dec.imm      = imm_u;
        dec.wen      = 1'b1;
      end
      OPC_LOAD: begin
        dec.aluop    = {1'b0, ALU_ADD};
        dec.src2_sel = SRC2_IMM;
        dec.imm      = imm_i;
        dec.wen      = 1'b1;
      end
      OPC_STORE: begin
        dec.aluop    = {1'b0, ALU_ADD};
        dec.src2_sel = SRC2_IMM;
        dec.imm      = imm_s;
      end
      OPC_BRANCH: begin
        dec.aluop = {1'b0, branch_op(f3)};
        dec.imm   = imm_b;
        if (f3 == 3'b010 || f3 == 3'b011) bad = 1'b1;
      end
      OPC_JAL: begin
        dec.aluop    = ALU_JUMP;
        dec.src1_sel = SRC1_PC;
        dec.src2_sel = SRC2_IMM;
        dec.imm      = imm_j;
        dec.wen      = 1'b1;
      end
      OPC_JALR: begin
        dec.aluop    = ALU_JUMP;
        dec.src2_sel = SRC2_IMM;
        dec.imm      = imm_i;
        dec.wen      = 1'b1;
        if (f3 != 3'b000) bad = 1'b1;
      end
      default: bad = 1'b1;
    endcase

    if (dec.rd == 5'd0) dec.wen = 1'b0;

    if (bad) begin
      dec.aluop    = '0;
      dec.src1_sel = '0;
      dec.src2_sel = 1'b0;
      dec.imm      = '0;
      dec.wen      = 1'b0;
      dec.illegal  = 1'b1;
    end
  end

endmodule

// File: rtl/aluop_issue.sv
// aluop_issue: decode-and-issue stage ahead of the ALU. Accepts RV32I
// instructions over valid/ready and presents one registered decoded bundle
// per instruction, in order, one cycle after acceptance.
// Build option ALUOP_ISSUE_SKID_EN: adds a skid entry so in_ready is a
// flop output; without it in_ready is combinational from out_ready.
module aluop_issue
  import aluop_pkg::*;
(
  input  logic        clk,
  input  logic        rstn,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_inst,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [5:0]  out_aluop,
  output logic [1:0]  out_src1_sel,
  output logic        out_src2_sel,
  output logic [31:0] out_imm,
  output logic [4:0]  out_rs1,
  output logic [4:0]  out_rs2,
  output logic [4:0]  out_rd,
  output logic        out_wen,
  output logic        out_illegal
);

  bundle_t dec;
  bundle_t main_q;
  occ_e    state_q;
  occ_e    state_d;
  logic    accept;
  logic    consume;
  logic    ld_main_dec;

`ifdef ALUOP_ISSUE_SKID_EN
  bundle_t skid_q;
  logic    in_ready_q;
  logic    ld_main_skid;
  logic    ld_skid;
`endif

  aluop_decode u_decode (
    .inst (in_inst),
    .dec  (dec)
  );

  assign accept  = in_valid && in_ready;
  assign consume = out_valid && out_ready;

  // Occupancy state register (and registered in_ready in the skid build)
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q    <= OCC_EMPTY;
`ifdef ALUOP_ISSUE_SKID_EN
      in_ready_q <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
`ifdef ALUOP_ISSUE_SKID_EN
      in_ready_q <= (state_d != OCC_TWO);
`endif
    end
  end

  // Next occupancy and which register loads on this edge
  always_comb begin
    state_d      = state_q;
    ld_main_dec  = 1'b0;
`ifdef ALUOP_ISSUE_SKID_EN
    ld_main_skid = 1'b0;
    ld_skid      = 1'b0;
    case (state_q)
      OCC_EMPTY: begin
        if (accept) begin
          state_d     = OCC_ONE;
          ld_main_dec = 1'b1;
        end
      end
      OCC_ONE: begin
        if (accept && consume) begin
          ld_main_dec = 1'b1;
        end else if (accept) begin
          state_d = OCC_TWO;
          ld_skid = 1'b1;
        end else if (consume) begin
          state_d = OCC_EMPTY;
        end
      end
      OCC_TWO: begin
        // in_ready is low here, so the skid entry drains before new input
        if (consume) begin
          state_d      = OCC_ONE;
          ld_main_skid = 1'b1;
        end
      end
      default: state_d = OCC_EMPTY;
    endcase
`else
    case (state_q)
      OCC_EMPTY: begin
        if (accept) begin
          state_d     = OCC_ONE;
          ld_main_dec = 1'b1;
        end
      end
      OCC_ONE: begin
        // accepting while full implies the consumer takes the bundle this edge
        if (accept) begin
          ld_main_dec = 1'b1;
        end else if (consume) begin
          state_d = OCC_EMPTY;
        end
      end
      default: state_d = OCC_EMPTY;
    endcase
`endif
  end

  // Handshake outputs from the occupancy state
  always_comb begin
    out_valid = (state_q != OCC_EMPTY);
`ifdef ALUOP_ISSUE_SKID_EN
    in_ready  = in_ready_q;
`else
    in_ready  = (state_q == OCC_EMPTY) || out_ready;
`endif
  end

  // Bundle storage: main register drives the outputs, skid absorbs one stall
  always_ff @(posedge clk) begin
    if (!rstn) begin
      main_q <= '0;
`ifdef ALUOP_ISSUE_SKID_EN
      skid_q <= '0;
`endif
    end else begin
      if (ld_main_dec) begin
        main_q <= dec;
      end
`ifdef ALUOP_ISSUE_SKID_EN
      else if (ld_main_skid) begin
        main_q <= skid_q;
      end
      if (ld_skid) begin
        skid_q <= dec;
      end
`endif
    end
  end

  assign out_aluop    = main_q.aluop;
  assign out_src1_sel = main_q.src1_sel;
  assign out_src2_sel = main_q.src2_sel;
  assign out_imm      = main_q.imm;
  assign out_rs1      = main_q.rs1;
  assign out_rs2      = main_q.rs2;
  assign out_rd       = main_q.rd;
  assign out_wen      = main_q.wen;
  assign out_illegal  = main_q.illegal;

endmodule

// File: tb/tb_aluop_issue.sv
// tb_aluop_issue: scoreboard bench for aluop_issue with directed vectors.
module tb_aluop_issue;

  logic        clk;
  logic        rstn;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_inst;
  logic        out_valid;
  logic        out_ready;
  logic [5:0]  out_aluop;
  logic [1:0]  out_src1_sel;
  logic        out_src2_sel;
  logic [31:0] out_imm;
  logic [4:0]  out_rs1;
  logic [4:0]  out_rs2;
  logic [4:0]  out_rd;
  logic        out_wen;
  logic        out_illegal;

`ifdef ALUOP_ISSUE_SKID_EN
  localparam int EXP_ACC = 2;
`else
  localparam int EXP_ACC = 1;
`endif

  typedef struct {
    logic [31:0] inst;
    logic [5:0]  aluop;
    logic [1:0]  s1;
    logic        s2;
    logic [31:0] imm;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic        wen;
    logic        ill;
    bit          c1;
    bit          c2;
  } exp_t;

  exp_t vecs[$];
  exp_t sb[$];
  exp_t mon_e;
  int   total;
  int   passed;
  int   n_acc;
  int   n_out;

  aluop_issue dut (
    .clk          (clk),
    .rstn         (rstn),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_inst      (in_inst),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_aluop    (out_aluop),
    .out_src1_sel (out_src1_sel),
    .out_src2_sel (out_src2_sel),
    .out_imm      (out_imm),
    .out_rs1      (out_rs1),
    .out_rs2      (out_rs2),
    .out_rd       (out_rd),
    .out_wen      (out_wen),
    .out_illegal  (out_illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic exp_t mk(input logic [31:0] inst, input logic [5:0] aluop,
                              input logic [1:0] s1, input logic s2, input logic [31:0] imm,
                              input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                              input logic wen, input logic ill, input bit c1, input bit c2);
    exp_t e;
    e.inst = inst; e.aluop = aluop; e.s1 = s1; e.s2 = s2; e.imm = imm;
    e.rs1 = rs1; e.rs2 = rs2; e.rd = rd; e.wen = wen; e.ill = ill; e.c1 = c1; e.c2 = c2;
    return e;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
  endtask

  // Offer one instruction until accepted (bounded); expected bundle queued on acceptance
  task automatic send(input exp_t e);
    int unsigned cyc;
    bit done;
    cyc = 0;
    done = 0;
    in_valid = 1'b1;
    in_inst  = e.inst;
    while (!done) begin
      @(negedge clk);
      if (in_ready) begin
        sb.push_back(e);
        n_acc++;
        done = 1;
      end
      @(posedge clk);
      #1;
      if (!done) begin
        cyc++;
        if (cyc > 50) begin
          total++;
          $display("FAIL send_timeout: inst 0x%08h not accepted in %0d cycles", e.inst, cyc);
          done = 1;
        end
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int unsigned cyc;
    cyc = 0;
    while (sb.size() != 0 && cyc < 100) begin
      @(posedge clk);
      cyc++;
    end
    #1;
    chk("drain_left", sb.size(), 0);
  endtask

  // Monitor: every transfer on the output is compared against the oldest expectation
  always @(negedge clk) begin
    if (rstn && out_valid && out_ready) begin
      n_out++;
      if (sb.size() == 0) begin
        total++;
        $display("FAIL unexpected_bundle: got aluop 0x%02h rd %0d with nothing expected", out_aluop, out_rd);
      end else begin
        mon_e = sb.pop_front();
        chk($sformatf("aluop[%08h]", mon_e.inst), 32'(out_aluop), 32'(mon_e.aluop));
        chk($sformatf("src1[%08h]", mon_e.inst), 32'(out_src1_sel), 32'(mon_e.s1));
        chk($sformatf("src2[%08h]", mon_e.inst), 32'(out_src2_sel), 32'(mon_e.s2));
        chk($sformatf("imm[%08h]", mon_e.inst), out_imm, mon_e.imm);
        chk($sformatf("wen[%08h]", mon_e.inst), 32'(out_wen), 32'(mon_e.wen));
        chk($sformatf("illegal[%08h]", mon_e.inst), 32'(out_illegal), 32'(mon_e.ill));
        if (!mon_e.ill) chk($sformatf("rd[%08h]", mon_e.inst), 32'(out_rd), 32'(mon_e.rd));
        if (mon_e.c1) chk($sformatf("rs1[%08h]", mon_e.inst), 32'(out_rs1), 32'(mon_e.rs1));
        if (mon_e.c2) chk($sformatf("rs2[%08h]", mon_e.inst), 32'(out_rs2), 32'(mon_e.rs2));
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    total = 0; passed = 0; n_acc = 0; n_out = 0;
    rstn = 1'b0; in_valid = 1'b0; in_inst = '0; out_ready = 1'b1;

    //                 inst          aluop      s1     s2    imm           rs1 rs2 rd wen ill c1 c2
    vecs.push_back(mk(32'h002081B3, 6'b000000, 2'b00, 1'b0, 32'h00000000, 1, 2, 3, 1, 0, 1, 1)); // add x3,x1,x2
    vecs.push_back(mk(32'h402081B3, 6'b000001, 2'b00, 1'b0, 32'h00000000, 1, 2, 3, 1, 0, 1, 1)); // sub
    vecs.push_back(mk(32'h40335293, 6'b001011, 2'b00, 1'b1, 32'h00000003, 6, 0, 5, 1, 0, 1, 0)); // srai x5,x6,3
    vecs.push_back(mk(32'h00208463, 6'b010000, 2'b00, 1'b0, 32'h00000008, 1, 2, 8, 0, 0, 1, 1)); // beq +8
    vecs.push_back(mk(32'h010000EF, 6'b100000, 2'b01, 1'b1, 32'h00000010, 0, 0, 1, 1, 0, 0, 0)); // jal x1,+16
    vecs.push_back(mk(32'hFE000033, 6'b000000, 2'b00, 1'b0, 32'h00000000, 0, 0, 0, 0, 1, 0, 0)); // bad funct7
    vecs.push_back(mk(32'h0000000B, 6'b000000, 2'b00, 1'b0, 32'h00000000, 0, 0, 0, 0, 1, 0, 0)); // unknown opcode
    vecs.push_back(mk(32'h00000013, 6'b000000, 2'b00, 1'b1, 32'h00000000, 0, 0, 0, 0, 0, 1, 0)); // addi x0 -> wen 0
    vecs.push_back(mk(32'h00208033, 6'b000000, 2'b00, 1'b0, 32'h00000000, 1, 2, 0, 0, 0, 1, 1)); // add x0 -> wen 0
    vecs.push_back(mk(32'h123452B7, 6'b000000, 2'b10, 1'b1, 32'h12345000, 0, 0, 5, 1, 0, 0, 0)); // lui
    vecs.push_back(mk(32'hFFFFF397, 6'b000000, 2'b01, 1'b1, 32'hFFFFF000, 0, 0, 7, 1, 0, 0, 0)); // auipc
    vecs.push_back(mk(32'hFFC12203, 6'b000000, 2'b00, 1'b1, 32'hFFFFFFFC, 2, 0, 4, 1, 0, 1, 0)); // lw x4,-4(x2)
    vecs.push_back(mk(32'h00532623, 6'b000000, 2'b00, 1'b1, 32'h0000000C, 6, 5, 12, 0, 0, 1, 1)); // sw x5,12(x6)
    vecs.push_back(mk(32'h004100E7, 6'b100000, 2'b00, 1'b1, 32'h00000004, 2, 0, 1, 1, 0, 1, 0)); // jalr x1,4(x2)
    vecs.push_back(mk(32'h004110E7, 6'b000000, 2'b00, 1'b0, 32'h00000000, 0, 0, 0, 0, 1, 0, 0)); // jalr funct3 001
    vecs.push_back(mk(32'h0020A463, 6'b000000, 2'b00, 1'b0, 32'h00000000, 0, 0, 0, 0, 1, 0, 0)); // branch funct3 010
    vecs.push_back(mk(32'h40131293, 6'b000000, 2'b00, 1'b0, 32'h00000000, 0, 0, 0, 0, 1, 0, 0)); // slli funct7 0x20
    vecs.push_back(mk(32'h4020F1B3, 6'b000000, 2'b00, 1'b0, 32'h00000000, 0, 0, 0, 0, 1, 0, 0)); // and with 0x20
    vecs.push_back(mk(32'h4020D1B3, 6'b001011, 2'b00, 1'b0, 32'h00000000, 1, 2, 3, 1, 0, 1, 1)); // sra
    vecs.push_back(mk(32'hFE20FEE3, 6'b011110, 2'b00, 1'b0, 32'hFFFFFFFC, 1, 2, 29, 0, 0, 1, 1)); // bgeu -4
    vecs.push_back(mk(32'h4000C193, 6'b001000, 2'b00, 1'b1, 32'h00000400, 1, 0, 3, 1, 0, 1, 0)); // xori, bit30 in imm

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("reset_out_valid", 32'(out_valid), 0);
    chk("reset_aluop", 32'(out_aluop), 0);
    chk("reset_imm", out_imm, 0);
    rstn = 1'b1;
    @(posedge clk);
    #1;
    chk("post_reset_in_ready", 32'(in_ready), 1);
    chk("post_reset_out_valid", 32'(out_valid), 0);

    // Back-to-back stream of all directed vectors with the consumer always ready
    foreach (vecs[i]) send(vecs[i]);
    drain();

    // Output stall while streaming three instructions
    out_ready = 1'b0;
    base = n_acc;
    fork
      begin
        send(vecs[0]);
        send(vecs[1]);
        send(vecs[3]);
      end
      begin
        repeat (6) @(posedge clk);
        #1;
        chk("stall_accepted", n_acc - base, EXP_ACC);
        chk("stall_in_ready", 32'(in_ready), 0);
        chk("stall_out_valid", 32'(out_valid), 1);
        chk("stall_hold_aluop", 32'(out_aluop), 32'(vecs[0].aluop));
        out_ready = 1'b1;
      end
    join
    drain();
    chk("stall_in_order_count", n_acc - base, 3);

    // Reset while bundles are buffered: nothing may emerge afterwards
    out_ready = 1'b0;
    send(vecs[1]);
`ifdef ALUOP_ISSUE_SKID_EN
    send(vecs[4]);
`endif
    rstn = 1'b0;
    sb.delete();
    @(posedge clk);
    #1;
    chk("midreset_out_valid", 32'(out_valid), 0);
    chk("midreset_aluop", 32'(out_aluop), 0);
    rstn = 1'b1;
    out_ready = 1'b1;
    base = n_out;
    repeat (5) @(posedge clk);
    #1;
    chk("no_stale_bundle", n_out - base, 0);
    chk("after_reset_in_ready", 32'(in_ready), 1);

    // Traffic resumes normally after the mid-stream reset
    send(vecs[2]);
    send(vecs[19]);
    drain();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
